// File: rtl/costas_pkg.sv
// Shared types and helpers for the Costas acquisition controller.
//   - acq_state_t : controller FSM state codes (IDLE..TRACK = 0..4)
//   - off()       : sweep offset in steps for a sweep index
//                   (0, +1, -1, +2, -2, ...)
//   - DW_DEF / FW_DEF / CENTER_DEF / STEP_DEF : default widths and tuning words
package costas_pkg;

    localparam int DW_DEF     = 26;         // I/Q arm sample width
    localparam int FW_DEF     = 30;         // NCO phase-increment width
    localparam int CENTER_DEF = 268435456;  // 2 MHz at an 8 MHz clock
    localparam int STEP_DEF   = 134218;     // ~1 kHz per sweep step

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_PULL_IN = 3'd3,
        S_TRACK   = 3'd4
    } acq_state_t;

    // Odd indices step upward, even indices mirror them downward, so the
    // search fans out symmetrically around the nominal carrier.
    function automatic int off(input int k);
        if (k == 0)
            return 0;
        else if (k % 2 == 1)
            return (k + 1) / 2;
        else
            return -(k / 2);
    endfunction

endpackage

// File: rtl/lock_metric_acc.sv
// Windowed lock-metric accumulator.
// Each valid sample adds d = |yi| - |yq| (|x| saturated so the most negative
// input maps to the largest positive value). On the 2^WIN_LOG2-th valid
// sample of a window, win_end strobes combinationally and metric carries the
// total including that sample; the accumulator then restarts from zero.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   run          : 0 holds the accumulator and window counter cleared
//   in_valid     : sample qualifier; 0 freezes counter and accumulator
//   yi, yq       : signed I/Q arm samples
//   win_end      : window-end strobe (same cycle as the last sample)
//   metric       : window sum including the current sample
module lock_metric_acc
    import costas_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int WIN_LOG2 = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       run,
    input  logic                       in_valid,
    input  logic signed [DW-1:0]       yi,
    input  logic signed [DW-1:0]       yq,
    output logic                       win_end,
    output logic signed [DW+WIN_LOG2:0] metric
);

    localparam int MW = DW + 1 + WIN_LOG2;

    logic [DW-1:0]        ai;
    logic [DW-1:0]        aq;
    logic signed [DW:0]   d;
    logic signed [MW-1:0] acc;
    logic [WIN_LOG2-1:0]  cnt;

    // Two's-complement negation of the most negative code would wrap back to
    // itself, so that code is clamped to the largest positive magnitude.
    function automatic logic [DW-1:0] abs_sat(input logic signed [DW-1:0] x);
        logic [DW-1:0] r;
        if (!x[DW-1])
            r = x;
        else if (x[DW-2:0] == '0)
            r = {1'b0, {(DW-1){1'b1}}};
        else
            r = -x;
        return r;
    endfunction

    assign ai      = abs_sat(yi);
    assign aq      = abs_sat(yq);
    assign d       = $signed({1'b0, ai}) - $signed({1'b0, aq});
    assign metric  = acc + MW'(d);
    assign win_end = run & in_valid & (&cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (!run) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            cnt <= cnt + 1'b1;  // wraps to 0 after the window-end sample
            acc <= win_end ? '0 : metric;
        end
    end

endmodule

// File: rtl/costas_acq_ctrl.sv
// Acquisition/tracking controller for the polarity Costas carrier loop.
// Sweeps the NCO base increment around CENTER, waits SETTLE_LEN valid
// samples after each retune, then qualifies lock from windowed |I|-|Q|
// metrics: LOCK_HITS consecutive passes select the narrow loop filter
// (TRACK), LOSS_MISSES consecutive fails in TRACK drop back to SETTLE.
// Build option: define COSTAS_ACQ_SWEEP_EN to enable the frequency sweep;
// without it carrier stays at CENTER and every retune reuses index 0.
// Ports:
//   clk, reset_n   : 8 MHz clock, async active-low reset
//   en             : run enable (0 returns to IDLE on the next edge)
//   in_valid,yi,yq : qualified signed I/Q arm samples
//   carrier        : NCO base phase increment
//   bw_sel         : 0 wide / 1 narrow loop filter
//   loop_clr       : one-cycle loop-filter integrator clear on each retune
//   locked         : lock indicator
//   state          : FSM state code
//   sweep_idx      : current sweep index (0..2*NSTEPS)
module costas_acq_ctrl
    import costas_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int FW          = FW_DEF,
    parameter int CENTER      = CENTER_DEF,
    parameter int STEP        = STEP_DEF,
    parameter int NSTEPS      = 8,
    parameter int WIN_LOG2    = 10,
    parameter int SETTLE_LEN  = 2048,
    parameter int LOCK_TH     = 0,
    parameter int LOCK_HITS   = 4,
    parameter int LOSS_MISSES = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] yi,
    input  logic signed [DW-1:0] yq,
    output logic [FW-1:0]        carrier,
    output logic                 bw_sel,
    output logic                 loop_clr,
    output logic                 locked,
    output logic [2:0]           state,
    output logic [4:0]           sweep_idx
);

`ifdef COSTAS_ACQ_SWEEP_EN
    localparam bit SWEEP_ON = 1'b1;
`else
    localparam bit SWEEP_ON = 1'b0;
`endif

    localparam int MW  = DW + 1 + WIN_LOG2;
    localparam int SCW = $clog2(SETTLE_LEN + 1);
    localparam int HCW = $clog2(LOCK_HITS + 1);
    localparam int MCW = $clog2(LOSS_MISSES + 1);
    localparam logic signed [MW-1:0] TH = MW'(LOCK_TH);

    acq_state_t           st, st_n;
    logic [4:0]           idx, idx_n, idx_step;
    logic [SCW-1:0]       settle_cnt, settle_n;
    logic [HCW-1:0]       hit_cnt, hit_n;
    logic [MCW-1:0]       miss_cnt, miss_n;
    logic [FW-1:0]        carrier_n;
    logic                 retune;
    logic                 run;
    logic                 win_end;
    logic                 pass;
    logic signed [MW-1:0] metric;

    // Carrier word for a sweep index; arithmetic is modulo 2^FW.
    function automatic logic [FW-1:0] carrier_of(input logic [4:0] k);
        longint sum;
        sum = longint'(CENTER) + longint'(off(int'(k))) * longint'(STEP);
        return sum[FW-1:0];
    endfunction

    // The metric only integrates once the loop has settled on a carrier.
    assign run = en && (st == S_MEASURE || st == S_PULL_IN || st == S_TRACK);

    lock_metric_acc #(
        .DW       (DW),
        .WIN_LOG2 (WIN_LOG2)
    ) u_metric (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .in_valid (in_valid),
        .yi       (yi),
        .yq       (yq),
        .win_end  (win_end),
        .metric   (metric)
    );

    assign pass     = metric > TH;
    assign idx_step = !SWEEP_ON                ? 5'd0 :
                      (idx == 5'(2 * NSTEPS))  ? 5'd0 : idx + 5'd1;

    always_comb begin
        st_n     = st;
        idx_n    = idx;
        settle_n = settle_cnt;
        hit_n    = hit_cnt;
        miss_n   = miss_cnt;
        retune   = 1'b0;
        if (!en) begin
            st_n     = S_IDLE;
            idx_n    = '0;
            settle_n = '0;
            hit_n    = '0;
            miss_n   = '0;
        end else begin
            case (st)
                S_IDLE: begin
                    st_n   = S_SETTLE;
                    idx_n  = '0;
                    retune = 1'b1;
                end
                S_SETTLE: if (in_valid) begin
                    if (settle_cnt == SCW'(SETTLE_LEN - 1)) begin
                        settle_n = '0;
                        st_n     = S_MEASURE;
                    end else begin
                        settle_n = settle_cnt + 1'b1;
                    end
                end
                S_MEASURE: if (win_end) begin
                    if (pass) begin
                        hit_n = HCW'(1);
                        st_n  = (LOCK_HITS <= 1) ? S_TRACK : S_PULL_IN;
                        miss_n = '0;
                    end else begin
                        idx_n    = idx_step;
                        st_n     = S_SETTLE;
                        settle_n = '0;
                        retune   = 1'b1;
                    end
                end
                S_PULL_IN: if (win_end) begin
                    if (pass) begin
                        hit_n = hit_cnt + 1'b1;
                        if (hit_cnt == HCW'(LOCK_HITS - 1)) begin
                            st_n   = S_TRACK;
                            miss_n = '0;
                        end
                    end else begin
                        idx_n    = idx_step;
                        st_n     = S_SETTLE;
                        settle_n = '0;
                        retune   = 1'b1;
                    end
                end
                S_TRACK: if (win_end) begin
                    if (pass) begin
                        miss_n = '0;
                    end else if (miss_cnt == MCW'(LOSS_MISSES - 1)) begin
                        // Lock lost: re-acquire on the same carrier first.
                        miss_n   = '0;
                        st_n     = S_SETTLE;
                        settle_n = '0;
                        retune   = 1'b1;
                    end else begin
                        miss_n = miss_cnt + 1'b1;
                    end
                end
                default: st_n = S_IDLE;
            endcase
        end

        carrier_n = carrier;
        if (st_n == S_IDLE)
            carrier_n = FW'(CENTER);
        else if (retune)
            carrier_n = carrier_of(idx_n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= S_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            carrier    <= FW'(CENTER);
            bw_sel     <= 1'b0;
            locked     <= 1'b0;
            loop_clr   <= 1'b0;
        end else begin
            st         <= st_n;
            idx        <= idx_n;
            settle_cnt <= settle_n;
            hit_cnt    <= hit_n;
            miss_cnt   <= miss_n;
            carrier    <= carrier_n;
            bw_sel     <= (st_n == S_TRACK);
            locked     <= (st_n == S_TRACK);
            loop_clr   <= retune;
        end
    end

    assign state     = st;
    assign sweep_idx = idx;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Self-checking bench for costas_acq_ctrl (small window/settle parameters).
// Directed table + hand sequences with constant expectations, then random
// traffic compared every cycle against a queue-based reference model.
module tb_costas_acq_ctrl;

    localparam int DW = 26, FW = 30;
    localparam int CENTER = 268435456, STEP = 134218, NSTEPS = 8;
    localparam int WIN_LOG2 = 4, WIN = 16, SETTLE_LEN = 8;
    localparam int LOCK_HITS = 4, LOSS_MISSES = 3;
    localparam int AMAX = 33554431;
    localparam int NEG  = -33554432;
`ifdef COSTAS_ACQ_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif

    logic                 clk;
    logic                 reset_n;
    logic                 en;
    logic                 in_valid;
    logic signed [DW-1:0] yi;
    logic signed [DW-1:0] yq;
    logic [FW-1:0]        carrier;
    logic                 bw_sel;
    logic                 loop_clr;
    logic                 locked;
    logic [2:0]           state;
    logic [4:0]           sweep_idx;

    costas_acq_ctrl #(
        .DW(DW), .FW(FW), .CENTER(CENTER), .STEP(STEP), .NSTEPS(NSTEPS),
        .WIN_LOG2(WIN_LOG2), .SETTLE_LEN(SETTLE_LEN), .LOCK_TH(0),
        .LOCK_HITS(LOCK_HITS), .LOSS_MISSES(LOSS_MISSES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid),
        .yi(yi), .yq(yq), .carrier(carrier), .bw_sel(bw_sel),
        .loop_clr(loop_clr), .locked(locked), .state(state),
        .sweep_idx(sweep_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit prev_clr = 1'b0;

    // ---------------- reference model ----------------
    int m_state, m_idx, m_carrier, m_settle, m_hits, m_miss;
    bit m_clr, m_lock;
    int win_q[$];

    function automatic int mag(input int x);
        int a;
        a = (x < 0) ? -x : x;
        if (a > AMAX) a = AMAX;
        return a;
    endfunction

    function automatic int carrier_for(input int k);
        longint w;
        int o;
        if (!SWEEP) return CENTER;
        o = (k == 0) ? 0 : (k % 2 == 1) ? (k + 1) / 2 : -(k / 2);
        w = (longint'(CENTER) + longint'(o) * STEP) % (longint'(1) << FW);
        if (w < 0) w = w + (longint'(1) << FW);
        return int'(w);
    endfunction

    function automatic int next_of(input int k);
        return SWEEP ? (k + 1) % (2 * NSTEPS + 1) : 0;
    endfunction

    task automatic m_reset();
        m_state = 0; m_idx = 0; m_carrier = CENTER; m_settle = 0;
        m_hits = 0; m_miss = 0; m_clr = 0; m_lock = 0;
        win_q.delete();
    endtask

    task automatic m_enter_settle(input int k);
        m_state = 1; m_idx = k; m_carrier = carrier_for(k);
        m_clr = 1; m_settle = 0; win_q.delete();
    endtask

    task automatic m_step(input bit e, input bit v, input int a, input int b);
        int metric;
        bit pass;
        m_clr = 0;
        if (!e) begin
            m_state = 0; m_idx = 0; m_carrier = CENTER; m_settle = 0;
            m_hits = 0; m_miss = 0; win_q.delete();
        end else if (m_state == 0) begin
            m_enter_settle(0);
        end else if (m_state == 1) begin
            if (v) begin
                m_settle++;
                if (m_settle == SETTLE_LEN) begin m_state = 2; win_q.delete(); end
            end
        end else if (v) begin
            win_q.push_back(mag(a) - mag(b));
            if (win_q.size() == WIN) begin
                metric = win_q.sum();
                win_q.delete();
                pass = metric > 0;
                if (m_state == 2) begin
                    if (pass) begin m_state = 3; m_hits = 1; end
                    else m_enter_settle(next_of(m_idx));
                end else if (m_state == 3) begin
                    if (pass) begin
                        m_hits++;
                        if (m_hits == LOCK_HITS) begin m_state = 4; m_miss = 0; end
                    end else m_enter_settle(next_of(m_idx));
                end else begin
                    if (pass) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_miss == LOSS_MISSES) begin m_miss = 0; m_enter_settle(m_idx); end
                    end
                end
            end
        end
        m_lock = (m_state == 4);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".state"},    longint'(state),     longint'(m_state));
        chk({tag, ".idx"},      longint'(sweep_idx), longint'(m_idx));
        chk({tag, ".carrier"},  longint'(carrier),   longint'(m_carrier));
        chk({tag, ".bw_sel"},   longint'(bw_sel),    longint'(m_lock));
        chk({tag, ".locked"},   longint'(locked),    longint'(m_lock));
        chk({tag, ".loop_clr"}, longint'(loop_clr),  longint'(m_clr));
        chk({tag, ".clr_twice"}, longint'(prev_clr & loop_clr), 0);
        prev_clr = loop_clr;
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic tick(input bit e, input bit v, input int a, input int b);
        en = e; in_valid = v; yi = DW'(a); yq = DW'(b);
        @(posedge clk);
        m_step(e, v, a, b);
        cyc++;
        #1;
        compare_all("model");
    endtask

    task automatic do_reset();
        reset_n = 1'b0; en = 1'b0; in_valid = 1'b0; yi = '0; yq = '0;
        #2;
        m_reset();
        prev_clr = 1'b0;
        compare_all("reset");
        chk("reset.state", longint'(state), 0);
        chk("reset.carrier", longint'(carrier), CENTER);
        chk("reset.loop_clr", longint'(loop_clr), 0);
        chk("reset.locked", longint'(locked), 0);
        chk("reset.bw_sel", longint'(bw_sel), 0);
        chk("reset.idx", longint'(sweep_idx), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit en;
        bit v;
        int st;
        bit clr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int st_before;
        int exp_idx;
        reset_n = 1'b0; en = 1'b0; in_valid = 1'b0; yi = '0; yq = '0;

        tbl[0] = '{en: 0, v: 0, st: 0, clr: 0};
        tbl[1] = '{en: 1, v: 0, st: 1, clr: 1};
        tbl[2] = '{en: 1, v: 0, st: 1, clr: 0};
        tbl[3] = '{en: 1, v: 1, st: 1, clr: 0};
        tbl[4] = '{en: 0, v: 1, st: 0, clr: 0};
        tbl[5] = '{en: 1, v: 1, st: 1, clr: 1};

        @(posedge clk); #1;
        do_reset();

        // enable/drop handshake table
        for (int i = 0; i < 6; i++) begin
            tick(tbl[i].en, tbl[i].v, 1000, 0);
            chk($sformatf("tbl%0d.state", i), longint'(state), tbl[i].st);
            chk($sformatf("tbl%0d.clr", i), longint'(loop_clr), tbl[i].clr);
            chk($sformatf("tbl%0d.carrier", i), longint'(carrier), CENTER);
        end

        // steady pass: TRACK after 8 + 4*16 valid samples
        for (int i = 1; i <= 72; i++) begin
            tick(1, 1, 1000, 0);
            if (i == 8)  chk("lock.measure", longint'(state), 2);
            if (i == 24) chk("lock.pull_in", longint'(state), 3);
            if (i == 71) chk("lock.st71", longint'(state), 3);
        end
        chk("lock.state", longint'(state), 4);
        chk("lock.locked", longint'(locked), 1);
        chk("lock.bw_sel", longint'(bw_sel), 1);

        // TRACK: fail, fail, pass, fail, fail, fail
        st_before = int'(sweep_idx);
        for (int w = 0; w < 6; w++) begin
            for (int j = 0; j < WIN; j++)
                tick(1, 1, (w == 2) ? 1000 : 0, (w == 2) ? 0 : 1000);
            if (w < 5) chk($sformatf("loss.w%0d.state", w), longint'(state), 4);
        end
        chk("loss.state", longint'(state), 1);
        chk("loss.locked", longint'(locked), 0);
        chk("loss.bw_sel", longint'(bw_sel), 0);
        chk("loss.clr", longint'(loop_clr), 1);
        chk("loss.idx", longint'(sweep_idx), st_before);

        // continuous fail: retune every 8 + 16 samples
        for (int r = 1; r <= 17; r++) begin
            for (int j = 1; j <= 24; j++) tick(1, 1, 0, 1000);
            exp_idx = SWEEP ? (r % 17) : 0;
            chk($sformatf("sweep%0d.clr", r), longint'(loop_clr), 1);
            chk($sformatf("sweep%0d.idx", r), longint'(sweep_idx), exp_idx);
            chk($sformatf("sweep%0d.carrier", r), longint'(carrier), carrier_for(exp_idx));
        end

        // saturation: |-2^25| == 2^25-1, so this window nets to zero (fail)
        for (int j = 1; j <= 8; j++) tick(1, 1, 0, 0);
        for (int j = 1; j <= 16; j++) tick(1, 1, NEG, AMAX);
        chk("sat.zero_fails", longint'(state), 1);
        for (int j = 1; j <= 8; j++) tick(1, 1, 0, 0);
        for (int j = 1; j <= 16; j++) tick(1, 1, NEG, 0);
        chk("sat.positive", longint'(state), 3);

        // 50% in_valid doubles the window
        for (int i = 1; i <= 32; i++) begin
            tick(1, (i % 2 == 0), 0, 1000);
            if (i == 31) chk("half.st31", longint'(state), 3);
        end
        chk("half.st32", longint'(state), 1);

        // en dropped in PULL_IN
        for (int j = 1; j <= 24; j++) tick(1, 1, 1000, 0);
        chk("endrop.pull_in", longint'(state), 3);
        for (int j = 1; j <= 5; j++) tick(1, 1, 1000, 0);
        tick(0, 1, 1000, 0);
        chk("endrop.state", longint'(state), 0);
        chk("endrop.clr", longint'(loop_clr), 0);
        chk("endrop.carrier", longint'(carrier), CENTER);
        tick(1, 1, 1000, 0);
        chk("reen.clr", longint'(loop_clr), 1);

        // reset pulse in TRACK
        for (int j = 1; j <= 72; j++) tick(1, 1, 1000, 0);
        chk("rst.track", longint'(state), 4);
        for (int j = 1; j <= 5; j++) tick(1, 1, 1000, 0);
        do_reset();

        // random traffic against the model
        for (int blk = 0; blk < 200; blk++) begin
            int mode;
            mode = $urandom_range(0, 5);
            for (int j = 0; j < 16; j++) begin
                int a, b;
                bit e, v;
                if ($urandom_range(0, 999) == 0) do_reset();
                a = int'($urandom_range(0, 67108863)) + NEG;
                b = int'($urandom_range(0, 67108863)) + NEG;
                if (mode <= 2) b = int'($urandom_range(0, 255)) - 128;
                else if (mode == 3) a = int'($urandom_range(0, 255)) - 128;
                else if (mode == 4) begin
                    a = int'($urandom_range(0, 7)) - 4;
                    b = int'($urandom_range(0, 7)) - 4;
                end
                e = ($urandom_range(0, 299) != 0);
                v = ($urandom_range(0, 9) != 0);
                tick(e, v, a, b);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/costas_acq_ctrl.md
# costas_acq_ctrl

Acquisition/tracking controller for the polarity Costas carrier-recovery loop. It watches the low-pass-filtered I/Q arm outputs and computes a windowed lock metric. It drives the NCO base phase increment through a frequency-search sweep, clears the loop-filter integrator on each retune, and switches the loop-filter bandwidth from wide (pull-in) to narrow (tracking) once lock is confirmed. It sits beside the Costas datapath: it consumes `yi`/`yq` and produces `carrier`, `bw_sel` and `loop_clr`.

## Interface
- `DW`, 26, I/Q arm sample width (signed)
- `FW`, 30, NCO phase-increment width
- `CENTER`, 268435456, nominal carrier word (2 MHz at 8 MHz clk)
- `STEP`, 134218, sweep step (~1 kHz)
- `NSTEPS`, 8, sweep half-span; indices 0..2*NSTEPS
- `WIN_LOG2`, 10, metric window = 2^WIN_LOG2 valid samples
- `SETTLE_LEN`, 2048, valid samples ignored after each retune
- `LOCK_TH`, 0, signed metric threshold (metric > LOCK_TH = pass)
- `LOCK_HITS`, 4, consecutive passes PULL_IN→TRACK
- `LOSS_MISSES`, 3, consecutive fails TRACK→SETTLE

Ports:
- `clk` in 1: system clock, 8 MHz
- `reset_n` in 1: asynchronous, active-low reset
- `en` in 1: run enable, level-sensitive
- `in_valid` in 1: `yi`/`yq` qualifier
- `yi` in DW: in-phase arm, signed
- `yq` in DW: quadrature arm, signed
- `carrier` out FW: NCO base phase increment
- `bw_sel` out 1: 0 = wide loop filter, 1 = narrow
- `loop_clr` out 1: one-cycle pulse that clears the loop-filter integrator
- `locked` out 1: lock indicator
- `state` out 3: current FSM state code
- `sweep_idx` out 5: current sweep index

## Operation
- Per valid sample, accumulate `d = |yi| - |yq|`.
  - `|x|` saturates −2^(DW−1) to 2^(DW−1)−1.
  - `d` is DW+1 bits signed; the accumulator is DW+1+WIN_LOG2 bits signed and cannot overflow.
- Window end is the 2^WIN_LOG2-th valid sample. On that sample:
  - metric = accumulator including it;
  - the accumulator restarts at 0.
- Sweep offset for index k: `off(k) = ceil(k/2)`, positive for odd k, negative for even k>0, 0 for k=0. The sequence is 0, +1, −1, +2, −2, …
- `carrier = CENTER + off(k)*STEP`, modulo 2^FW (wraps, no saturation).
- States:
  - IDLE=0: `carrier`=CENTER, `bw_sel`=0, `locked`=0, idx=0. On `en`=1 → SETTLE.
  - SETTLE=1:
    - On entry: `carrier` updates and `loop_clr` pulses on the same edge.
    - After SETTLE_LEN valid samples: accumulator cleared → MEASURE.
  - MEASURE=2: at window end:
    - pass → PULL_IN with hit count = 1;
    - fail → idx+1, wrapping 2*NSTEPS→0, → SETTLE.
  - PULL_IN=3: `bw_sel`=0. At each window end:
    - pass → hit count +1; when it reaches LOCK_HITS → TRACK;
    - fail → idx+1 → SETTLE.
  - TRACK=4: `bw_sel`=1, `locked`=1. At each window end:
    - fail → miss count +1; a pass resets miss count to 0;
    - miss count = LOSS_MISSES → `locked`=0, `bw_sel`=0, → SETTLE with idx unchanged.
- `en`=0 in any state → IDLE on the next edge. Counters and accumulator clear. No `loop_clr` pulse.
- `in_valid`=0 freezes all sample counters and the accumulator. FSM state holds.
- `reset_n` asserted mid-operation: all state clears immediately, whatever the current state.

## Timing
- Reset values:
  - `carrier`=CENTER
  - `bw_sel`=0, `loop_clr`=0, `locked`=0
  - `state`=0, `sweep_idx`=0
- All outputs are registered.
- Decision latency: state, `carrier`, `bw_sel`, `locked` and `loop_clr` change on the same edge that accepts the window-end sample.
- `en` rising → SETTLE on the next edge; `loop_clr` is high for exactly that one cycle.
- `loop_clr` is never high for two consecutive cycles.

## Configuration
- `COSTAS_ACQ_SWEEP_EN` defined: frequency sweep as above.
- Not defined:
  - `carrier` is fixed at CENTER and `sweep_idx` is tied to 0;
  - a MEASURE/PULL_IN fail re-enters SETTLE at idx 0, still pulsing `loop_clr`.

## Structure
- Package `costas_pkg` holds:
  - state enum (IDLE…TRACK codes);
  - `off(k)` function;
  - DW/FW width constants;
  - default CENTER/STEP.
- Sub-module `lock_metric_acc` holds the abs/saturate, difference, window counter and accumulator. It outputs metric plus a window-end strobe.
- The top level holds the FSM, sweep indexing and carrier arithmetic.

## Test plan
- Reset, then `en`=1 → one-cycle `loop_clr`, `state`=1, `carrier`=268435456.
- `yi`=+1000, `yq`=0 every cycle, WIN_LOG2=4, SETTLE_LEN=8, LOCK_HITS=4 → TRACK after 8+4·16 valid samples; `locked`=1, `bw_sel`=1.
- `yi`=0, `yq`=+1000 → idx sequence 0,1,2,…,16,0. `carrier` = CENTER, +134218, −134218, … ; a `loop_clr` pulse at each retune.
- In TRACK, 2 failing windows then 1 passing, then 3 failing → stays in TRACK until the 3rd consecutive fail, then SETTLE with `locked`=0 and the same idx.
- `yi`=−2^25 → abs saturates to 2^25−1, with no sign flip of metric. Toggle `in_valid` 50% → window duration doubles.
- `en` dropped in PULL_IN, and separately `reset_n` pulsed in TRACK → IDLE/reset values, with no `loop_clr`.
